// File: rtl/snn_layer_scheduler.sv
// rtl/snn_layer_scheduler.sv - steps one shared Izhikevich core through the H1/H2/OUT neurons per tick
module snn_layer_scheduler #(
  parameter int N_IN  = 2,
  parameter int N_H1  = 4,
  parameter int N_H2  = 4,
  parameter int N_OUT = 2,
  parameter int MAXN  = 4,
  parameter int IDXW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_IN-1:0]  spike_in,
  output logic             core_req,
  input  logic             core_ready,
  output logic [1:0]       core_layer,
  output logic [IDXW-1:0]  core_idx,
  output logic [MAXN-1:0]  core_pre_spikes,
  input  logic             core_valid,
  input  logic             core_spike,
  output logic [N_OUT-1:0] spike_out,
  output logic             step_done,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [IDXW-1:0] LAST_H1  = IDXW'(N_H1 - 1);
  localparam logic [IDXW-1:0] LAST_H2  = IDXW'(N_H2 - 1);
  localparam logic [IDXW-1:0] LAST_OUT = IDXW'(N_OUT - 1);

  state_t            state, state_nxt;
  logic [1:0]        layer;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   last_idx;
  logic [N_IN-1:0]   in_buf;
  logic [N_H1-1:0]   h1_vec;
  logic [N_H2-1:0]   h2_vec;
  logic [N_OUT-1:0]  out_vec;

  always_comb begin
    case (layer)
      2'd1:    last_idx = LAST_H1;
      2'd2:    last_idx = LAST_H2;
      default: last_idx = LAST_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request fields come straight from layer/idx, which only move in WAIT,
  // so they stay stable for as long as the core holds off core_ready.
  always_comb begin
    state_nxt       = state;
    core_req        = 1'b0;
    core_layer      = 2'd0;
    core_idx        = '0;
    core_pre_spikes = '0;
    case (state)
      IDLE: begin
        if (tick) state_nxt = ISSUE;
      end
      ISSUE: begin
        core_req   = 1'b1;
        core_layer = layer;
        core_idx   = idx;
        case (layer)
          2'd1:    core_pre_spikes = MAXN'(in_buf);
          2'd2:    core_pre_spikes = MAXN'(h1_vec);
          2'd3:    core_pre_spikes = MAXN'(h2_vec);
          default: core_pre_spikes = '0;
        endcase
        if (core_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (core_valid) begin
          if (idx == last_idx && layer == 2'd3) state_nxt = DONE;
          else                                  state_nxt = ISSUE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layer     <= 2'd0;
      idx       <= '0;
      in_buf    <= '0;
      h1_vec    <= '0;
      h2_vec    <= '0;
      out_vec   <= '0;
      spike_out <= '0;
      step_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            in_buf  <= spike_in;
            layer   <= 2'd1;
            idx     <= '0;
            h1_vec  <= '0;
            h2_vec  <= '0;
            out_vec <= '0;
          end
        end
        WAIT: begin
          if (core_valid) begin
            // Per-bit compare keeps the index in range for layers narrower than 2^IDXW.
            for (int i = 0; i < N_H1; i++)
              if (layer == 2'd1 && idx == IDXW'(i)) h1_vec[i] <= core_spike;
            for (int i = 0; i < N_H2; i++)
              if (layer == 2'd2 && idx == IDXW'(i)) h2_vec[i] <= core_spike;
            for (int i = 0; i < N_OUT; i++)
              if (layer == 2'd3 && idx == IDXW'(i)) out_vec[i] <= core_spike;
            if (idx == last_idx) begin
              if (layer != 2'd3) begin
                layer <= layer + 2'd1;
                idx   <= '0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          spike_out <= out_vec;
          step_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// tb/tb_snn_layer_scheduler.sv - randomized self-checking bench for snn_layer_scheduler
module tb_snn_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] spike_in = 2'b00;
  logic       core_req;
  logic       core_ready = 1'b0;
  logic [1:0] core_layer;
  logic [1:0] core_idx;
  logic [3:0] core_pre_spikes;
  logic       core_valid = 1'b0;
  logic       core_spike = 1'b0;
  logic [1:0] spike_out;
  logic       step_done;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad = 0;

  snn_layer_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spike_in(spike_in),
    .core_req(core_req), .core_ready(core_ready), .core_layer(core_layer),
    .core_idx(core_idx), .core_pre_spikes(core_pre_spikes),
    .core_valid(core_valid), .core_spike(core_spike),
    .spike_out(spike_out), .step_done(step_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Core model: mask bit (layer-1)*4+idx is the spike the core returns for that neuron.
  logic [9:0] resp_mask = '0;
  int         stall_n = 0;
  int         stall_cnt = 0;
  bit         stray_en = 0;
  bit         acc_prev = 0;
  logic [1:0] acc_l, acc_i;
  logic [7:0] hold;
  logic [7:0] req_log[$];
  int         unstable = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         done_edge = -1;
  int         t0 = 0;

  function automatic logic resp_bit(input logic [1:0] l, input logic [1:0] i);
    return resp_mask[(int'(l) - 1) * 4 + int'(i)];
  endfunction

  // Expected request sequence: each layer is fed the previous layer's mask bits.
  function automatic int log_errors(input logic [9:0] m, input logic [1:0] si);
    logic [7:0] exp_q[$];
    int n = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 2'(i), {2'b00, si}});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 2'(i), m[3:0]});
    for (int i = 0; i < 2; i++) exp_q.push_back({2'd3, 2'(i), m[7:4]});
    if (req_log.size() != 10) return 99;
    for (int i = 0; i < 10; i++) if (req_log[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic step_cycle();
    @(negedge clk);
    tick = 1'b0;
    core_valid = 1'b0;
    if (acc_prev) begin
      core_valid = 1'b1;
      core_spike = resp_bit(acc_l, acc_i);
      acc_prev = 0;
    end
    if (core_req) begin
      if (stall_cnt == 0) hold = {core_layer, core_idx, core_pre_spikes};
      else if ({core_layer, core_idx, core_pre_spikes} !== hold) unstable++;
      if (stall_cnt >= stall_n) begin
        core_ready = 1'b1;
        req_log.push_back({core_layer, core_idx, core_pre_spikes});
        acc_prev = 1; acc_l = core_layer; acc_i = core_idx;
        stall_cnt = 0;
      end else begin
        core_ready = 1'b0;
        stall_cnt++;
        if (stray_en && !core_valid) begin
          core_valid = 1'b1;
          core_spike = 1'b1;
        end
      end
    end else begin
      core_ready = (stall_n == 0);
      stall_cnt = 0;
    end
    if (busy) busy_cnt++;
    if (step_done) begin
      done_cnt++;
      done_edge = edge_n - t0;
    end
  endtask

  task automatic start_tick(input logic [1:0] si);
    tick = 1'b1;
    spike_in = si;
    t0 = edge_n + 1;
    busy_cnt = 0; done_cnt = 0; done_edge = -1; unstable = 0;
    req_log.delete();
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      step_cycle();
      if (done_cnt > 0) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step_cycle();
    total++;
    if ({core_req, core_layer, core_idx, core_pre_spikes} !== 9'd0) begin
      $display("FAIL reset_req got=%h want=0", {core_req, core_layer, core_idx, core_pre_spikes}); bad++;
    end
    total++;
    if ({spike_out, step_done, busy, overrun} !== 5'd0) begin
      $display("FAIL reset_status got=%b want=00000", {spike_out, step_done, busy, overrun}); bad++;
    end
    rst_n = 1'b1;
    step_cycle();
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    stall_n = 0; resp_mask = 10'b10_0000_0000;
    start_tick(2'b11);
    wait_done(100, ok);
    total++;
    if (!ok) begin $display("FAIL basic_timeout got=no step_done want=step_done"); bad++; end
    total++;
    if (done_edge !== 21) begin $display("FAIL basic_latency got=%0d want=21", done_edge); bad++; end
    total++;
    if (busy_cnt !== 21) begin $display("FAIL basic_busy got=%0d want=21", busy_cnt); bad++; end
    total++;
    if (spike_out !== 2'b10) begin $display("FAIL basic_spike_out got=%b want=10", spike_out); bad++; end
    repeat (5) step_cycle();
    total++;
    if (done_cnt !== 1) begin $display("FAIL basic_done_once got=%0d want=1", done_cnt); bad++; end
    n = log_errors(resp_mask, 2'b11);
    total++;
    if (n !== 0) begin $display("FAIL basic_sequence got=%0d bad entries want=0", n); bad++; end
  endtask

  task automatic test_forwarding();
    bit ok;
    int n;
    stall_n = 0; resp_mask = 10'b00_1000_0101;
    start_tick(2'b01);
    wait_done(100, ok);
    total++;
    if (!ok) begin $display("FAIL fwd_timeout got=no step_done want=step_done"); bad++; end
    total++;
    if (req_log.size() != 10 || req_log[4][3:0] !== 4'b0101 || req_log[9][3:0] !== 4'b1000) begin
      $display("FAIL fwd_pre got=%0d entries want=10 with 0101/1000", req_log.size()); bad++;
    end
    n = log_errors(resp_mask, 2'b01);
    total++;
    if (n !== 0) begin $display("FAIL fwd_sequence got=%0d bad entries want=0", n); bad++; end
    total++;
    if (spike_out !== 2'b00) begin $display("FAIL fwd_spike_out got=%b want=00", spike_out); bad++; end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    stall_n = 3; resp_mask = 10'b10_0000_0000;
    start_tick(2'b11);
    wait_done(200, ok);
    total++;
    if (done_edge !== 51) begin $display("FAIL bp_latency got=%0d want=51", done_edge); bad++; end
    total++;
    if (unstable !== 0) begin $display("FAIL bp_stable got=%0d changes want=0", unstable); bad++; end
    total++;
    if (spike_out !== 2'b10) begin $display("FAIL bp_spike_out got=%b want=10", spike_out); bad++; end
    n = log_errors(resp_mask, 2'b11);
    total++;
    if (n !== 0) begin $display("FAIL bp_sequence got=%0d bad entries want=0", n); bad++; end
    stall_n = 0;
  endtask

  task automatic test_overrun_stray();
    bit ok;
    int n;
    logic [1:0] si;
    stall_n = 1; stray_en = 1; resp_mask = '0;
    si = 2'($urandom_range(0, 3));
    start_tick(si);
    repeat (5) step_cycle();
    tick = 1'b1;
    step_cycle();
    total++;
    if (overrun !== 1'b1) begin $display("FAIL ovr_set got=%b want=1", overrun); bad++; end
    wait_done(200, ok);
    total++;
    if (done_edge !== 31) begin $display("FAIL ovr_latency got=%0d want=31", done_edge); bad++; end
    repeat (10) step_cycle();
    total++;
    if (done_cnt !== 1) begin $display("FAIL ovr_done_once got=%0d want=1", done_cnt); bad++; end
    total++;
    if (overrun !== 1'b1) begin $display("FAIL ovr_sticky got=%b want=1", overrun); bad++; end
    n = log_errors(resp_mask, si);
    total++;
    if (n !== 0) begin $display("FAIL ovr_stray_sequence got=%0d bad entries want=0", n); bad++; end
    total++;
    if (spike_out !== 2'b00) begin $display("FAIL stray_spike_out got=%b want=00", spike_out); bad++; end
    stall_n = 0; stray_en = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic [1:0] si;
    stall_n = 0; resp_mask = 10'b11_0000_0000;
    start_tick(2'b10);
    wait_done(100, ok);
    resp_mask = 10'($urandom);
    start_tick(2'b11);
    for (int i = 0; i < 100 && !(req_log.size() == 6 && acc_prev); i++) step_cycle();
    step_cycle();
    total++;
    if (core_valid !== 1'b1 || spike_out !== 2'b11) begin
      $display("FAIL rst_setup got=valid %b out %b want=valid 1 out 11", core_valid, spike_out); bad++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    core_valid = 1'b1; core_spike = 1'b1;
    acc_prev = 0; stall_cnt = 0;
    total++;
    if ({core_req, busy, spike_out, overrun} !== 5'd0) begin
      $display("FAIL rst_mid_state got=%b want=00000", {core_req, busy, spike_out, overrun}); bad++;
    end
    @(negedge clk);
    core_valid = 1'b0;
    total++;
    if ({core_req, busy, step_done} !== 3'd0) begin
      $display("FAIL rst_late_valid got=%b want=000", {core_req, busy, step_done}); bad++;
    end
    si = 2'($urandom_range(0, 3));
    resp_mask = 10'($urandom);
    start_tick(si);
    wait_done(100, ok);
    n = log_errors(resp_mask, si);
    total++;
    if (!ok || n !== 0) begin $display("FAIL rst_after_step got=%0d bad entries want=0", n); bad++; end
    total++;
    if (spike_out !== resp_mask[9:8]) begin
      $display("FAIL rst_after_out got=%b want=%b", spike_out, resp_mask[9:8]); bad++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [1:0] si;
    stall_n = 0; resp_mask = 10'($urandom);
    start_tick(2'($urandom_range(0, 3)));
    wait_done(100, ok);
    si = 2'($urandom_range(0, 3));
    resp_mask = 10'($urandom);
    start_tick(si);
    step_cycle();
    total++;
    if (overrun !== 1'b0) begin $display("FAIL b2b_overrun got=%b want=0", overrun); bad++; end
    step_cycle();
    total++;
    if (req_log.size() < 1 || req_log[0][7:4] !== 4'b0100) begin
      $display("FAIL b2b_first_req got=%0d entries want=layer 1 idx 0", req_log.size()); bad++;
    end
    wait_done(100, ok);
    n = log_errors(resp_mask, si);
    total++;
    if (!ok || n !== 0) begin $display("FAIL b2b_sequence got=%0d bad entries want=0", n); bad++; end
    total++;
    if (spike_out !== resp_mask[9:8]) begin
      $display("FAIL b2b_spike_out got=%b want=%b", spike_out, resp_mask[9:8]); bad++;
    end
    total++;
    if (done_edge !== 21) begin $display("FAIL b2b_latency got=%0d want=21", done_edge); bad++; end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [1:0] si;
    for (int k = 0; k < 4; k++) begin
      si = 2'($urandom_range(0, 3));
      resp_mask = 10'($urandom);
      stall_n = int'($urandom_range(0, 2));
      start_tick(si);
      wait_done(200, ok);
      n = log_errors(resp_mask, si);
      total++;
      if (!ok || n !== 0) begin $display("FAIL rand_sequence[%0d] got=%0d bad entries want=0", k, n); bad++; end
      total++;
      if (spike_out !== resp_mask[9:8]) begin
        $display("FAIL rand_spike_out[%0d] got=%b want=%b", k, spike_out, resp_mask[9:8]); bad++;
      end
      total++;
      if (done_edge !== 21 + 10 * stall_n) begin
        $display("FAIL rand_latency[%0d] got=%0d want=%0d", k, done_edge, 21 + 10 * stall_n); bad++;
      end
      repeat (3) step_cycle();
    end
    stall_n = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forwarding();
    test_backpressure();
    test_random();
    test_overrun_stray();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
